// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU op encodings, control bundle
// and the immediate-format lookup used by imm_gen.
package riscv_pkg;

    localparam int NREGADDR = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [2:0] F3_SR   = 3'b101;

    typedef struct packed {
        logic src_a_pc;
        logic src_b_imm;
        logic mem_rd;
        logic mem_wr;
        logic reg_wr;
        logic branch;
        logic jump;
    } id_ctrl_t;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_fmt = IMM_I;
            OPC_STORE:                      imm_fmt = IMM_S;
            OPC_BRANCH:                     imm_fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             imm_fmt = IMM_U;
            OPC_JAL:                        imm_fmt = IMM_J;
            default:                        imm_fmt = IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; format is chosen from the opcode,
// result sign-extended from instr[31] to NBITS.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [31:0]      instr,
    output logic [NBITS-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_fmt(instr[6:0]))
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = NBITS'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register read, immediate/control decode, load-use stall
// and ID/EX register. Define DECODE_ILLEGAL_EN to pass unsupported opcodes on as traps.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int NBITS    = 32,
    parameter int NREGADDR = riscv_pkg::NREGADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    input  logic [31:0]         if_instr,
    input  logic [NBITS-1:0]    if_pc,
    output logic                id_ready,
    input  logic                ex_ready,
    input  logic                flush,
    output logic                rf_rd1,
    output logic                rf_rd2,
    output logic [NREGADDR-1:0] rf_add_rd1,
    output logic [NREGADDR-1:0] rf_add_rd2,
    input  logic [NBITS-1:0]    rf_out1,
    input  logic [NBITS-1:0]    rf_out2,
    output logic                id_valid,
    output logic [NBITS-1:0]    id_pc,
    output logic [NBITS-1:0]    id_rs1_data,
    output logic [NBITS-1:0]    id_rs2_data,
    output logic [NBITS-1:0]    id_imm,
    output logic [NREGADDR-1:0] id_rd,
    output logic [3:0]          id_alu_op,
`ifdef DECODE_ILLEGAL_EN
    output logic                id_illegal,
`endif
    output logic [6:0]          id_ctrl
);

    typedef struct packed {
        logic                valid;
        logic [NBITS-1:0]    pc;
        logic [NBITS-1:0]    rs1_data;
        logic [NBITS-1:0]    rs2_data;
        logic [NBITS-1:0]    imm;
        logic [NREGADDR-1:0] rd;
        logic [3:0]          alu_op;
        id_ctrl_t            ctrl;
    } idex_t;

    idex_t idex_q, idex_d, dec;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [NREGADDR-1:0] rs1, rs2, rd;
    logic [NBITS-1:0]    imm;
    logic                use1, use2, wr_op, legal, hazard, upd, take;
    logic [3:0]          alu_op;
    id_ctrl_t            ctrl;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign rs1    = NREGADDR'(if_instr[19:15]);
    assign rs2    = NREGADDR'(if_instr[24:20]);
    assign rd     = NREGADDR'(if_instr[11:7]);

    imm_gen #(.NBITS(NBITS)) u_imm_gen (
        .instr (if_instr),
        .imm   (imm)
    );

    always_comb begin
        ctrl   = '0;
        use1   = 1'b0;
        use2   = 1'b0;
        wr_op  = 1'b0;
        legal  = 1'b1;
        alu_op = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                use1 = 1'b1; use2 = 1'b1; wr_op = 1'b1;
                alu_op = {if_instr[30], funct3};
            end
            OPC_OP_IMM: begin
                use1 = 1'b1; wr_op = 1'b1; ctrl.src_b_imm = 1'b1;
                // bit 30 of an I-immediate only selects SRA vs SRL
                alu_op = {(funct3 == F3_SR) & if_instr[30], funct3};
            end
            OPC_LOAD: begin
                use1 = 1'b1; wr_op = 1'b1;
                ctrl.src_b_imm = 1'b1; ctrl.mem_rd = 1'b1;
            end
            OPC_STORE: begin
                use1 = 1'b1; use2 = 1'b1;
                ctrl.src_b_imm = 1'b1; ctrl.mem_wr = 1'b1;
            end
            OPC_BRANCH: begin
                use1 = 1'b1; use2 = 1'b1; ctrl.branch = 1'b1;
                alu_op = {1'b0, funct3};
            end
            OPC_JAL: begin
                wr_op = 1'b1; ctrl.jump = 1'b1;
                ctrl.src_a_pc = 1'b1; ctrl.src_b_imm = 1'b1;
            end
            OPC_JALR: begin
                use1 = 1'b1; wr_op = 1'b1;
                ctrl.jump = 1'b1; ctrl.src_b_imm = 1'b1;
            end
            OPC_LUI: begin
                wr_op = 1'b1; ctrl.src_b_imm = 1'b1;
            end
            OPC_AUIPC: begin
                wr_op = 1'b1; ctrl.src_a_pc = 1'b1; ctrl.src_b_imm = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        ctrl.reg_wr = wr_op && (rd != '0);
    end

    // Unused ports read x0, which also gives LUI its zero rs1 operand
    assign rf_rd1     = use1;
    assign rf_rd2     = use2;
    assign rf_add_rd1 = use1 ? rs1 : '0;
    assign rf_add_rd2 = use2 ? rs2 : '0;

    assign hazard = if_valid && idex_q.valid && idex_q.ctrl.mem_rd && (idex_q.rd != '0) &&
                    ((use1 && rs1 == idex_q.rd) || (use2 && rs2 == idex_q.rd));
    assign upd    = !idex_q.valid || ex_ready;
    assign take   = if_valid && !hazard;

    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = if_pc;
        dec.rs1_data = rf_out1;
        dec.rs2_data = rf_out2;
        dec.imm      = imm;
        dec.rd       = ctrl.reg_wr ? rd : '0;
        dec.alu_op   = legal ? alu_op : ALU_ADD;
        dec.ctrl     = ctrl;

        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (upd) begin
`ifdef DECODE_ILLEGAL_EN
            idex_d = take ? dec : '0;
`else
            idex_d = (take && legal) ? dec : '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idex_q <= '0;
        else      idex_q <= idex_d;
    end

`ifdef DECODE_ILLEGAL_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q;
        if (flush)    illegal_d = 1'b0;
        else if (upd) illegal_d = take && !legal;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) illegal_q <= 1'b0;
        else      illegal_q <= illegal_d;
    end

    assign id_illegal = illegal_q;
`endif

    assign id_ready    = rst && (flush || (upd && !hazard));
    assign id_valid    = idex_q.valid;
    assign id_pc       = idex_q.pc;
    assign id_rs1_data = idex_q.rs1_data;
    assign id_rs2_data = idex_q.rs2_data;
    assign id_imm      = idex_q.imm;
    assign id_rd       = idex_q.rd;
    assign id_alu_op   = idex_q.alu_op;
    assign id_ctrl     = idex_q.ctrl;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: per-cycle expected ID/EX contents are queued
// when an input is driven and compared after the following clock edge.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, ex_ready, flush;
    logic [31:0] if_instr, if_pc;
    logic        id_ready, rf_rd1, rf_rd2, id_valid;
    logic [4:0]  rf_add_rd1, rf_add_rd2, id_rd;
    logic [31:0] rf_out1, rf_out2, id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]  id_alu_op;
    logic [6:0]  id_ctrl;
`ifdef DECODE_ILLEGAL_EN
    logic        id_illegal;
`endif

    logic [31:0] regs [32];
    assign rf_out1 = regs[rf_add_rd1];
    assign rf_out2 = regs[rf_add_rd2];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .rf_add_rd1(rf_add_rd1), .rf_add_rd2(rf_add_rd2),
        .rf_out1(rf_out1), .rf_out2(rf_out2), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rd(id_rd), .id_alu_op(id_alu_op),
`ifdef DECODE_ILLEGAL_EN
        .id_illegal(id_illegal),
`endif
        .id_ctrl(id_ctrl)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [6:0]  ctrl;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    localparam exp_t BUB = '0;
    localparam logic [31:0] ADDI = 32'hFFD08293, LW = 32'h0000A103, ADD = 32'h002101B3,
                            BEQ  = 32'hFE208CE3, BAD = 32'hFFFFFFFF, LUI = 32'h123453B7,
                            SW   = 32'h0020A423, SRAI = 32'h4030D213, AUIPC = 32'h00001317,
                            NOPW = 32'h00100013;

    function automatic exp_t mk(input logic [31:0] pc, r1, r2, imm, input logic [4:0] rd,
                                input logic [3:0] alu, input logic [6:0] ctrl);
        mk = {1'b1, pc, r1, r2, imm, rd, alu, ctrl};
    endfunction

    function automatic exp_t obs();
        obs = {id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rd, id_alu_op, id_ctrl};
    endfunction

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Entered just after a rising edge; drives one cycle of stimulus.
    task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                        input logic v, input logic exr, input logic fl, input logic rdy,
                        input exp_t exp, input logic rfchk = 1'b0, input logic [11:0] exp_rf = '0);
        exp_t e;
        if_instr = ins; if_pc = pc; if_valid = v; ex_ready = exr; flush = fl;
        #1;
        chk({tag, "/ready"}, id_ready, rdy);
        if (rfchk) chk({tag, "/rf"}, {rf_rd1, rf_rd2, rf_add_rd1, rf_add_rd2}, exp_rf);
        sb.push_back(exp);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(tag, obs(), e);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[1] = 32'h10;
        regs[2] = 32'h22;
        rst = 1'b0; if_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0;
        if_instr = '0; if_pc = '0;
        #3;
        chk("reset_state", obs(), BUB);
        chk("reset_ready", id_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;

        step("addi", ADDI, 32'h100, 1, 1, 0, 1, mk(32'h100, 32'h10, 0, 32'hFFFFFFFD, 5, 0, 7'h24),
             1'b1, {1'b1, 1'b0, 5'd1, 5'd0});
        step("lw",   LW,   32'h104, 1, 1, 0, 1, mk(32'h104, 32'h10, 0, 0, 2, 0, 7'h34));
        step("lu_stall", ADD, 32'h108, 1, 1, 0, 0, BUB, 1'b1, {1'b1, 1'b1, 5'd2, 5'd2});
        step("lu_add", ADD, 32'h108, 1, 1, 0, 1, mk(32'h108, 32'h22, 32'h22, 0, 3, 0, 7'h04));

        step("bp_addi", ADDI, 32'h10C, 1, 1, 0, 1, mk(32'h10C, 32'h10, 0, 32'hFFFFFFFD, 5, 0, 7'h24));
        for (int i = 0; i < 3; i++)
            step("bp_hold", ADD, 32'h110, 1, 0, 0, 0, mk(32'h10C, 32'h10, 0, 32'hFFFFFFFD, 5, 0, 7'h24));
        step("bp_release", ADD, 32'h110, 1, 1, 0, 1, mk(32'h110, 32'h22, 32'h22, 0, 3, 0, 7'h04));

        step("fl_lw",    LW,  32'h114, 1, 1, 0, 1, mk(32'h114, 32'h10, 0, 0, 2, 0, 7'h34));
        step("fl_flush", ADD, 32'h118, 1, 1, 1, 1, BUB);

        step("beq", BEQ, 32'h200, 1, 1, 0, 1, mk(32'h200, 32'h10, 32'h22, 32'hFFFFFFF8, 0, 0, 7'h02));
`ifdef DECODE_ILLEGAL_EN
        step("illegal", BAD, 32'h204, 1, 1, 0, 1, mk(32'h204, 0, 0, 0, 0, 0, 7'h00));
        chk("illegal_flag", id_illegal, 1'b1);
`else
        step("illegal", BAD, 32'h204, 1, 1, 0, 1, BUB);
`endif
        step("lui",   LUI,   32'h208, 1, 1, 0, 1, mk(32'h208, 0, 0, 32'h12345000, 7, 0, 7'h24),
             1'b1, 12'h000);
`ifdef DECODE_ILLEGAL_EN
        chk("illegal_clear", id_illegal, 1'b0);
`endif
        step("sw",    SW,    32'h20C, 1, 1, 0, 1, mk(32'h20C, 32'h10, 32'h22, 8, 0, 0, 7'h28));
        step("srai",  SRAI,  32'h210, 1, 1, 0, 1, mk(32'h210, 32'h10, 0, 32'h403, 4, 4'hD, 7'h24));
        step("auipc", AUIPC, 32'h214, 1, 1, 0, 1, mk(32'h214, 0, 0, 32'h1000, 6, 0, 7'h64));
        step("addi_x0", NOPW, 32'h218, 1, 1, 0, 1, mk(32'h218, 0, 0, 1, 0, 0, 7'h20));
        step("idle",  ADDI,  32'h21C, 0, 1, 0, 1, BUB);

        step("lubp_lw",   LW,  32'h21C, 1, 1, 0, 1, mk(32'h21C, 32'h10, 0, 0, 2, 0, 7'h34));
        step("lubp_hold", ADD, 32'h220, 1, 0, 0, 0, mk(32'h21C, 32'h10, 0, 0, 2, 0, 7'h34));
        step("lubp_bub",  ADD, 32'h220, 1, 1, 0, 0, BUB);
        step("lubp_add",  ADD, 32'h220, 1, 1, 0, 1, mk(32'h220, 32'h22, 32'h22, 0, 3, 0, 7'h04));

        step("mid_addi", ADDI, 32'h300, 1, 1, 0, 1, mk(32'h300, 32'h10, 0, 32'hFFFFFFFD, 5, 0, 7'h24));
        #1 rst = 1'b0;
        #1;
        chk("mid_reset", obs(), BUB);
        chk("mid_reset_ready", id_ready, 1'b0);
        @(posedge clk); #1;
        chk("reset_held", obs(), BUB);
        rst = 1'b1;
        if_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I instruction decode stage of the risc-v-lite core, between fetch and execute. Takes the fetched instruction and PC, drives the register-file read ports (`rd1`/`rd2`, `add_rd1`/`add_rd2`), captures the combinational read data `out1`/`out2`, generates the sign-extended immediate and control bundle, and registers everything into the ID/EX pipeline register. It also detects load-use hazards, applies EX backpressure and handles branch flush.

## Interface
- `NBITS`, 32, datapath width
- `NREGADDR`, 5, register address width
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `if_valid` in 1: fetch presents a valid instruction
- `if_instr` in 32: instruction word
- `if_pc` in NBITS: its PC
- `id_ready` out 1: instruction accepted this cycle when `if_valid && id_ready`
- `ex_ready` in 1: EX consumes ID/EX contents this cycle
- `flush` in 1: taken branch/jump in EX; kill decode and ID/EX
- `rf_rd1`, `rf_rd2` out 1: register-file read enables
- `rf_add_rd1`, `rf_add_rd2` out NREGADDR: read addresses
- `rf_out1`, `rf_out2` in NBITS: same-cycle read data
- `id_valid` out 1: ID/EX holds a live instruction
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm` out NBITS
- `id_rd` out NREGADDR: destination, 0 when no write
- `id_alu_op` out 4: {funct7[5], funct3}, ADD (0000) for address/link ops
- `id_ctrl` out 7: {src_a_pc, src_b_imm, mem_rd, mem_wr, reg_wr, branch, jump}

## Operation
- Opcodes: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC. Any other opcode is a bubble (see Configuration).
- Immediates: I/S/B/U/J formats, sign bit `if_instr[31]`. B/J have bit 0 = 0. U places bits 31:12, low bits zero.
- `rf_rd1` is asserted for OP, OP-IMM, LOAD, STORE, BRANCH and JALR. `rf_rd2` is asserted for OP, STORE and BRANCH. Unused addresses are driven to 0.
- LUI forces `rf_add_rd1=0`, so `id_rs1_data=0` and EX computes 0+imm.
- AUIPC and JAL set `src_a_pc`.
- `id_alu_op[3]` = funct7[5] only for OP, and for OP-IMM with funct3=101. Otherwise it is 0.
- `reg_wr` is 1 only if rd≠0 and the opcode writes a register.
- Load-use hazard: ID/EX holds a valid `mem_rd` entry with `id_rd≠0`, and `id_rd` equals a read-enabled source of the instruction in decode. The stage then drives `id_ready=0` and loads a bubble into ID/EX. The instruction is held upstream and decodes on the next cycle.
- ID/EX update condition: `!id_valid || ex_ready`.
  - If true, load either the decoded instruction (`if_valid && !hazard`) or a bubble.
  - If false, hold ID/EX and drive `id_ready=0`.
- `id_ready = !flush_hazard_blocked`, precisely:
  - `id_ready = flush || ((!id_valid || ex_ready) && !hazard)`
  - `id_ready` is 0 while `rst` is low.
- Flush has top priority over stall, hazard and backpressure. The instruction in decode is discarded and ID/EX becomes a bubble at the next edge.

## Timing
- Decode and register read are combinational from `if_instr`.
- Latency is one cycle: an accepted instruction appears on `id_*` after the next rising edge.
- Reset: asynchronous. All `id_*` outputs are forced to 0 immediately, including `id_valid=0` and `id_ctrl=0`. Reset mid-stream drops the in-flight entry.
- A hazard stall lasts exactly one cycle per load unless `ex_ready=0` extends it.
- `flush` together with a hazard or with `ex_ready=0`: `id_valid=0` after the edge.
- A bubble always has `id_ctrl=0` and `id_rd=0`.

## Configuration
- `DECODE_ILLEGAL_EN` defined:
  - Adds output `id_illegal` (1 bit, reset 0).
  - An unsupported opcode is accepted with `id_valid=1`, `id_illegal=1` and `id_ctrl=0` so EX can trap.
- `DECODE_ILLEGAL_EN` undefined:
  - No port.
  - An unsupported opcode is accepted and silently becomes a bubble.

## Structure
- `riscv_pkg`:
  - opcode localparams
  - ALU op constants
  - `id_ctrl_t` packed struct (7 bits, order above)
  - `NREGADDR`
- Sub-module `imm_gen`: combinational instruction → immediate by format.
- Hazard logic and ID/EX register live in the top module.

## Test plan
- Reset: `rst` low asynchronously while `id_valid=1` → all `id_*` 0 before the next edge, and `id_ready=0`.
- ADDI x5,x1,-3 (0xFFD08293) with `rf_out1=0x10` → `rf_add_rd1=1`, `rf_rd2=0`. Next edge: `id_valid=1`, `id_rd=5`, `id_imm=0xFFFFFFFD`, `id_rs1_data=0x10`, `src_b_imm=1`, `reg_wr=1`, `id_alu_op=0000`.
- Load-use: LW x2,0(x1) (0x0000A103), then ADD x3,x2,x2 (0x002101B3) → one cycle `id_ready=0` with a bubble in ID/EX. ADD is registered the following edge.
- Backpressure: `ex_ready=0` for 3 cycles with ADDI in ID/EX → outputs stable and `id_ready=0`. On release, the next instruction loads.
- Flush during a load-use stall → `id_valid=0` after the edge, held instruction discarded, `id_ready=1` during the flush cycle.
- BEQ x1,x2,-8 (0xFE208CE3) → `id_imm=0xFFFFFFF8`, `branch=1`, `reg_wr=0`, `id_rd=0`. With `DECODE_ILLEGAL_EN`, 0xFFFFFFFF → `id_illegal=1`. Without it, 0xFFFFFFFF → `id_valid=0`.
